// File: rtl/cv32e40p_apu_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_apu_core_pkg
// Description : Shared widths and constants for the APU master slice.
//               APU_* widths describe the core/FPU request and response
//               payloads. The request-side FSM state encodings and the default
//               in-flight depth are also defined here.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_apu_core_pkg;

    // Core <-> FPU payload widths
    localparam int APU_NARGS_CPU    = 3;
    localparam int APU_WOP_CPU      = 6;
    localparam int APU_NDSFLAGS_CPU = 15;
    localparam int APU_NUSFLAGS_CPU = 5;

    // Default number of in-flight FPU operations
    localparam int APU_DEPTH_DEFAULT = 4;

    // Request FSM state encodings
    localparam int          ST_W    = 1;
    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_REQ  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_apu_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_apu_tag_fifo
// Description : In-order FIFO of destination register tags for FPU operations
//               that have been granted but not yet answered. Supports a
//               same-cycle push/pop bypass when empty (zero-latency FPU) and
//               provides a RAW hazard compare across valid entries plus the
//               pending (not yet granted) request tag.
// Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//               push_i, push_addr_i   - store a tag (grant cycle)
//               pop_i                 - response arrived, retire head tag
//               pop_valid_o           - a tag was retired this cycle
//               pop_addr_o            - the retired tag
//               count_o               - number of valid entries
//               pend_valid_i/addr_i   - request waiting for grant
//               chk_addr_i, hazard_o  - RAW hazard check
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_apu_tag_fifo
    import cv32e40p_apu_core_pkg::*;
#(
    parameter  int DEPTH  = APU_DEPTH_DEFAULT,
    parameter  int ADDR_W = 6,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic              pop_i,
    output logic              pop_valid_o,
    output logic [ADDR_W-1:0] pop_addr_o,
    output logic [CNT_W-1:0]  count_o,
    input  logic              pend_valid_i,
    input  logic [ADDR_W-1:0] pend_addr_i,
    input  logic [ADDR_W-1:0] chk_addr_i,
    output logic              hazard_o
);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;

    logic w_empty, w_full, w_bypass, w_pop_eff, w_store;
    logic [DEPTH-1:0] w_hit_vec;

    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == CNT_W'(DEPTH));
    // Empty FIFO with push and pop together: the tag flows straight through
    assign w_bypass  = w_empty && push_i && pop_i;
    assign w_pop_eff = pop_i && !w_empty;
    assign w_store   = push_i && !w_bypass && (!w_full || w_pop_eff);

    assign pop_valid_o = w_pop_eff || w_bypass;
    assign pop_addr_o  = w_empty ? push_addr_i : mem_q[rd_ptr_q];
    assign count_o     = count_q;

    always_comb begin
        count_d = count_q;
        case ({w_store, w_pop_eff})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (w_store) begin
                mem_q[wr_ptr_q] <= push_addr_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop_eff) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the
    // count; stale slots beyond that must never raise a hazard.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hz
        logic [PTR_W-1:0] w_off;
        assign w_off         = PTR_W'(gi) - rd_ptr_q;
        assign w_hit_vec[gi] = ({1'b0, w_off} < count_q) && (mem_q[gi] == chk_addr_i);
    end

    assign hazard_o = (|w_hit_vec) || (pend_valid_i && (pend_addr_i == chk_addr_i));

endmodule
`default_nettype wire

// File: rtl/cv32e40p_apu_master.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_apu_master
// Description : Core-side APU master. Accepts one operation at a time from the
//               core, registers it and presents it to the FPU until granted,
//               tracks granted operations' destination registers in issue
//               order, and produces a registered writeback per FPU response.
// Ports       : clk_i, rst_i              - clock, synchronous active-high reset
//               req_*                     - core request (valid/ready)
//               apu_req_o/apu_gnt_i       - FPU request handshake
//               apu_operands/op/flags_o   - registered request payload
//               apu_rvalid/rdata/rflags_i - FPU response
//               wb_*                      - registered writeback to the core
//               chk_addr_i, hazard_o      - RAW hazard check
//               busy_o                    - pending or in-flight work
//               err_o                     - sticky: response with nothing in flight
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_apu_master
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int DEPTH  = APU_DEPTH_DEFAULT,
    parameter int ADDR_W = 6
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   req_valid_i,
    output logic                                   req_ready_o,
    input  logic [APU_NARGS_CPU-1:0][31:0]         req_operands_i,
    input  logic [APU_WOP_CPU-1:0]                 req_op_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]            req_flags_i,
    input  logic [ADDR_W-1:0]                      req_waddr_i,
    output logic                                   apu_req_o,
    input  logic                                   apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]         apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                 apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]            apu_flags_o,
    input  logic                                   apu_rvalid_i,
    input  logic [31:0]                            apu_rdata_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]            apu_rflags_i,
    output logic                                   wb_valid_o,
    output logic [ADDR_W-1:0]                      wb_waddr_o,
    output logic [31:0]                            wb_data_o,
    output logic [APU_NUSFLAGS_CPU-1:0]            wb_flags_o,
    input  logic [ADDR_W-1:0]                      chk_addr_i,
    output logic                                   hazard_o,
    output logic                                   busy_o,
    output logic                                   err_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ST_W-1:0]                    state_q, state_d;
    logic [APU_NARGS_CPU-1:0][31:0]     operands_q;
    logic [APU_WOP_CPU-1:0]             op_q;
    logic [APU_NDSFLAGS_CPU-1:0]        flags_q;
    logic [ADDR_W-1:0]                  waddr_q;
    logic                               wb_valid_q;
    logic [ADDR_W-1:0]                  wb_waddr_q;
    logic [31:0]                        wb_data_q;
    logic [APU_NUSFLAGS_CPU-1:0]        wb_flags_q;
    logic                               err_q;

    logic               w_accept, w_grant, w_in_req;
    logic               w_pop_valid;
    logic [ADDR_W-1:0]  w_pop_addr;
    logic [CNT_W-1:0]   w_count;

    assign w_in_req    = (state_q == ST_REQ);
    assign req_ready_o = (state_q == ST_IDLE) && (w_count < CNT_W'(DEPTH));
    assign w_accept    = req_valid_i && req_ready_o;
    // Grants seen while idle are meaningless and must not push a tag
    assign w_grant     = w_in_req && apu_gnt_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_accept) state_d = ST_REQ;
            ST_REQ:  if (apu_gnt_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            operands_q <= '0;
            op_q       <= '0;
            flags_q    <= '0;
            waddr_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_waddr_q <= '0;
            wb_data_q  <= '0;
            wb_flags_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (w_accept) begin
                operands_q <= req_operands_i;
                op_q       <= req_op_i;
                flags_q    <= req_flags_i;
                waddr_q    <= req_waddr_i;
            end
            wb_valid_q <= w_pop_valid;
            if (w_pop_valid) begin
                wb_waddr_q <= w_pop_addr;
                wb_data_q  <= apu_rdata_i;
                wb_flags_q <= apu_rflags_i;
            end
            // A response with no tag to match is dropped and flagged
            if (apu_rvalid_i && !w_pop_valid) begin
                err_q <= 1'b1;
            end
        end
    end

    cv32e40p_apu_tag_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_tag_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (w_grant),
        .push_addr_i  (waddr_q),
        .pop_i        (apu_rvalid_i),
        .pop_valid_o  (w_pop_valid),
        .pop_addr_o   (w_pop_addr),
        .count_o      (w_count),
        .pend_valid_i (w_in_req),
        .pend_addr_i  (waddr_q),
        .chk_addr_i   (chk_addr_i),
        .hazard_o     (hazard_o)
    );

    assign apu_req_o      = w_in_req;
    assign apu_operands_o = operands_q;
    assign apu_op_o       = op_q;
    assign apu_flags_o    = flags_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_waddr_o     = wb_waddr_q;
    assign wb_data_o      = wb_data_q;
    assign wb_flags_o     = wb_flags_q;
    assign busy_o         = w_in_req || (w_count != '0);
    assign err_o          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_apu_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_apu_master
// Description : Self-checking bench for cv32e40p_apu_master. A vector table of
//               single-op transactions plus directed sequences for full FIFO,
//               held grant, reset mid-flight and spurious responses. Expected
//               writebacks are queued when responses are driven and compared
//               by a monitor as they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_apu_master;
    import cv32e40p_apu_core_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 6;

    logic                              clk = 1'b0;
    logic                              rst_i;
    logic                              req_valid_i;
    logic                              req_ready_o;
    logic [APU_NARGS_CPU-1:0][31:0]    req_operands_i;
    logic [APU_WOP_CPU-1:0]            req_op_i;
    logic [APU_NDSFLAGS_CPU-1:0]       req_flags_i;
    logic [AW-1:0]                     req_waddr_i;
    logic                              apu_req_o;
    logic                              apu_gnt_i;
    logic [APU_NARGS_CPU-1:0][31:0]    apu_operands_o;
    logic [APU_WOP_CPU-1:0]            apu_op_o;
    logic [APU_NDSFLAGS_CPU-1:0]       apu_flags_o;
    logic                              apu_rvalid_i;
    logic [31:0]                       apu_rdata_i;
    logic [APU_NUSFLAGS_CPU-1:0]       apu_rflags_i;
    logic                              wb_valid_o;
    logic [AW-1:0]                     wb_waddr_o;
    logic [31:0]                       wb_data_o;
    logic [APU_NUSFLAGS_CPU-1:0]       wb_flags_o;
    logic [AW-1:0]                     chk_addr_i;
    logic                              hazard_o;
    logic                              busy_o;
    logic                              err_o;

    cv32e40p_apu_master #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_operands_i (req_operands_i),
        .req_op_i       (req_op_i),
        .req_flags_i    (req_flags_i),
        .req_waddr_i    (req_waddr_i),
        .apu_req_o      (apu_req_o),
        .apu_gnt_i      (apu_gnt_i),
        .apu_operands_o (apu_operands_o),
        .apu_op_o       (apu_op_o),
        .apu_flags_o    (apu_flags_o),
        .apu_rvalid_i   (apu_rvalid_i),
        .apu_rdata_i    (apu_rdata_i),
        .apu_rflags_i   (apu_rflags_i),
        .wb_valid_o     (wb_valid_o),
        .wb_waddr_o     (wb_waddr_o),
        .wb_data_o      (wb_data_o),
        .wb_flags_o     (wb_flags_o),
        .chk_addr_i     (chk_addr_i),
        .hazard_o       (hazard_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]               wa;
        logic [31:0]                 d;
        logic [APU_NUSFLAGS_CPU-1:0] f;
    } sb_t;

    typedef struct {
        logic [AW-1:0]               wa;
        logic [APU_WOP_CPU-1:0]      op;
        logic [31:0]                 rd;
        logic [APU_NUSFLAGS_CPU-1:0] rf;
        int                          gnt;
        int                          rsp;
        logic [AW-1:0]               chk;
        logic                        hz;
    } vec_t;

    int  n_checks = 0;
    int  n_err    = 0;
    int  wb_cnt   = 0;
    logic err_exp = 1'b0;

    sb_t             sb[$];
    logic [AW-1:0]   model[$];
    logic [AW-1:0]   cur_wa;
    logic [APU_NARGS_CPU-1:0][31:0] exp_ops;
    logic [APU_WOP_CPU-1:0]         exp_op;
    logic [APU_NDSFLAGS_CPU-1:0]    exp_flags;
    vec_t            tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Writeback monitor: every strobe must match the oldest expected result
    always @(negedge clk) begin
        if (wb_valid_o) begin
            wb_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL wb_unexpected: got waddr 0x%0h, required no writeback", wb_waddr_o);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("wb_waddr", 32'(wb_waddr_o), 32'(e.wa));
                chk("wb_data",  wb_data_o,        e.d);
                chk("wb_flags", 32'(wb_flags_o),  32'(e.f));
            end
        end
    end

    task automatic issue(input logic [AW-1:0] wa, input logic [APU_WOP_CPU-1:0] op);
        int n;
        req_valid_i    = 1'b1;
        req_waddr_i    = wa;
        req_op_i       = op;
        req_operands_i = {$urandom, $urandom, $urandom};
        req_flags_i    = APU_NDSFLAGS_CPU'($urandom);
        exp_ops   = req_operands_i;
        exp_op    = op;
        exp_flags = req_flags_i;
        cur_wa    = wa;
        n = 0;
        while (!req_ready_o && n < 50) begin
            cyc();
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'(req_ready_o), 32'd1);
        cyc();
        req_valid_i = 1'b0;
        chk("apu_req_after_accept", 32'(apu_req_o), 32'd1);
        chk("apu_operands0", apu_operands_o[0], exp_ops[0]);
        chk("apu_operands2", apu_operands_o[2], exp_ops[2]);
        chk("apu_flags", 32'(apu_flags_o), 32'(exp_flags));
    endtask

    task automatic grant();
        apu_gnt_i = 1'b1;
        model.push_back(cur_wa);
        cyc();
        apu_gnt_i = 1'b0;
        chk("apu_req_after_gnt", 32'(apu_req_o), 32'd0);
    endtask

    task automatic respond(input logic [31:0] d, input logic [APU_NUSFLAGS_CPU-1:0] f,
                           input logic gnt);
        logic exp_wb;
        apu_rvalid_i = 1'b1;
        apu_rdata_i  = d;
        apu_rflags_i = f;
        apu_gnt_i    = gnt;
        if (gnt) model.push_back(cur_wa);
        exp_wb = (model.size() > 0);
        if (exp_wb) begin
            sb.push_back('{model.pop_front(), d, f});
        end else begin
            err_exp = 1'b1;
        end
        cyc();
        apu_rvalid_i = 1'b0;
        apu_gnt_i    = 1'b0;
        chk("wb_valid_timing", 32'(wb_valid_o), 32'(exp_wb));
        chk("err_o", 32'(err_o), 32'(err_exp));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
        model.delete();
        err_exp = 1'b0;
    endtask

    initial begin
        tbl[0] = '{6'd5,  6'd1, 32'h3F80_0000, 5'h00, 2, 3, 6'd5,  1'b1};
        tbl[1] = '{6'd9,  6'd2, 32'h4000_0000, 5'h01, 1, 0, 6'd9,  1'b1};
        tbl[2] = '{6'd12, 6'd3, 32'hDEAD_BEEF, 5'h1F, 0, 1, 6'd7,  1'b0};
        tbl[3] = '{6'd63, 6'd4, 32'h0000_0001, 5'h10, 3, 2, 6'd63, 1'b1};
        tbl[4] = '{6'd0,  6'd5, 32'hC0A0_0000, 5'h04, 1, 1, 6'd12, 1'b0};
        tbl[5] = '{6'd33, 6'd6, 32'h1234_5678, 5'h0A, 0, 0, 6'd33, 1'b1};

        rst_i = 1'b1; req_valid_i = 1'b0; req_operands_i = '0; req_op_i = '0;
        req_flags_i = '0; req_waddr_i = '0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0;
        apu_rdata_i = '0; apu_rflags_i = '0; chk_addr_i = '0;
        do_reset();

        // Reset state
        chk("rst_apu_req",  32'(apu_req_o),  32'd0);
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_err",      32'(err_o),      32'd0);
        chk("rst_busy",     32'(busy_o),     32'd0);
        chk("rst_hazard",   32'(hazard_o),   32'd0);
        chk("rst_ready",    32'(req_ready_o), 32'd1);

        // Grant while idle must not create an in-flight entry
        apu_gnt_i = 1'b1;
        cyc();
        apu_gnt_i = 1'b0;
        chk("idle_gnt_busy", 32'(busy_o), 32'd0);

        // Vector table: single ops with varying grant/response latencies
        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].wa, tbl[i].op);
            chk("apu_op", 32'(apu_op_o), 32'(tbl[i].op));
            chk("ready_in_req", 32'(req_ready_o), 32'd0);
            chk_addr_i = tbl[i].chk;
            #0;
            chk("hazard_pending", 32'(hazard_o), 32'(tbl[i].hz));
            repeat (tbl[i].gnt) cyc();
            if (tbl[i].rsp == 0) begin
                respond(tbl[i].rd, tbl[i].rf, 1'b1);
                chk("zero_lat_busy", 32'(busy_o), 32'd0);
            end else begin
                grant();
                chk("hazard_inflight", 32'(hazard_o), 32'(tbl[i].hz));
                chk("busy_inflight", 32'(busy_o), 32'd1);
                repeat (tbl[i].rsp - 1) cyc();
                respond(tbl[i].rd, tbl[i].rf, 1'b0);
            end
            cyc();
            chk("wb_one_cycle", 32'(wb_valid_o), 32'd0);
        end

        // Fill the FIFO: 4 in flight, no responses
        for (int i = 1; i <= 4; i++) begin
            issue(AW'(i), 6'd7);
            grant();
        end
        chk("full_ready", 32'(req_ready_o), 32'd0);
        chk("full_busy",  32'(busy_o), 32'd1);
        chk_addr_i = 6'd3; #1;
        chk("full_hazard3", 32'(hazard_o), 32'd1);
        chk_addr_i = 6'd7; #1;
        chk("full_hazard7", 32'(hazard_o), 32'd0);
        req_valid_i = 1'b1;
        cyc();
        cyc();
        req_valid_i = 1'b0;
        chk("full_blocks_req", 32'(apu_req_o), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            respond(32'hA000_0000 + 32'(i), 5'(i), 1'b0);
        end
        cyc();
        chk("drained_busy", 32'(busy_o), 32'd0);

        // Held grant: payload stable for 10 cycles
        issue(6'd20, 6'd11);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("hold_req",   32'(apu_req_o), 32'd1);
            chk("hold_ready", 32'(req_ready_o), 32'd0);
            chk("hold_op",    32'(apu_op_o), 32'(exp_op));
            chk("hold_opnd1", apu_operands_o[1], exp_ops[1]);
            chk("hold_flags", 32'(apu_flags_o), 32'(exp_flags));
        end
        grant();
        respond(32'h5555_AAAA, 5'h03, 1'b0);
        cyc();

        // Reset with two ops in flight, then a late response
        issue(6'd40, 6'd1); grant();
        issue(6'd41, 6'd2); grant();
        do_reset();
        chk("mid_rst_req",  32'(apu_req_o),  32'd0);
        chk("mid_rst_busy", 32'(busy_o),     32'd0);
        chk("mid_rst_wb",   32'(wb_valid_o), 32'd0);
        chk("mid_rst_err",  32'(err_o),      32'd0);
        respond(32'h0BAD_0BAD, 5'h1, 1'b0);

        // Spurious response on an idle block: err sticky until reset
        do_reset();
        respond(32'hFFFF_0000, 5'h2, 1'b0);
        repeat (5) cyc();
        chk("err_sticky", 32'(err_o), 32'd1);
        do_reset();
        chk("err_cleared", 32'(err_o), 32'd0);

        repeat (3) cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Global watchdog so the bench always ends
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cv32e40p_apu_master.md
CV32E40P_APU_MASTER -- requirements
Module: cv32e40p_apu_master

Interface
REQ-001 SHALL have parameter DEPTH, default 4, max in-flight APU requests (power of two, 2..8).
REQ-002 SHALL have parameter ADDR_W, default 6, destination register address width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have the following ports:
- clk_i in 1: clock.
- rst_i in 1: sync active-high reset.
- req_valid_i in 1: core offers an op.
- req_ready_o out 1: op accepted this cycle when high with req_valid_i.
- req_operands_i in APU_NARGS_CPU x 32: operands.
- req_op_i in APU_WOP_CPU: op code.
- req_flags_i in APU_NDSFLAGS_CPU: formats and round mode.
- req_waddr_i in ADDR_W: destination register.
- apu_req_o out 1: request to FPU.
- apu_gnt_i in 1: FPU grant.
- apu_operands_o out APU_NARGS_CPU x 32: registered operands.
- apu_op_o out APU_WOP_CPU: registered op.
- apu_flags_o out APU_NDSFLAGS_CPU: registered flags.
- apu_rvalid_i in 1: FPU result valid.
- apu_rdata_i in 32: FPU result.
- apu_rflags_i in APU_NUSFLAGS_CPU: FPU status.
- wb_valid_o out 1: writeback strobe.
- wb_waddr_o out ADDR_W: writeback address.
- wb_data_o out 32: writeback data.
- wb_flags_o out APU_NUSFLAGS_CPU: writeback flags.
- chk_addr_i in ADDR_W: register checked for RAW hazard.
- hazard_o out 1: chk_addr_i matches any in-flight waddr (combinational).
- busy_o out 1: request pending or in-flight count non-zero.
- err_o out 1: sticky; response arrived with nothing in flight.

Function
REQ-005 SHALL implement FSM IDLE/REQ: IDLE->REQ on accept; REQ->IDLE on apu_gnt_i.
REQ-006 SHALL set req_ready_o = (state==IDLE) && (count < DEPTH).
REQ-007 SHALL capture operands/op/flags/waddr on accept and assert apu_req_o from the next cycle (1-cycle issue latency).
REQ-008 SHALL hold apu_req_o and all apu_* payload stable in REQ until apu_gnt_i.
REQ-009 SHALL push the captured waddr into the in-flight tag FIFO on the grant cycle.
REQ-010 SHALL pop the FIFO head on apu_rvalid_i and match responses strictly in issue order.
REQ-011 SHALL, on simultaneous push and pop, leave count unchanged; when count==0, the popped waddr is the one being pushed (bypass, zero-latency FPU).
REQ-012 SHALL register writeback: apu_rvalid_i at cycle t gives wb_valid_o for exactly one cycle at t+1, with the matched waddr and the rdata/rflags.
REQ-013 SHALL, on apu_rvalid_i with count==0 and no same-cycle grant, set err_o, drop the response and leave wb_valid_o low.
REQ-014 SHALL ignore apu_gnt_i outside REQ.
REQ-015 SHALL compare hazard_o against valid FIFO entries and the pending REQ waddr only.
REQ-016 SHALL wrap FIFO pointers modulo DEPTH; full (count==DEPTH) blocks accept; count never exceeds DEPTH.

Reset
REQ-017 SHALL, on rst_i, force state IDLE, count 0, pointers 0, err_o 0 and all outputs 0, including apu_req_o and wb_valid_o.
REQ-018 SHALL, on reset mid-operation, abandon any pending request and in-flight tags; later responses set err_o per REQ-013.

Structure
REQ-019 SHALL take APU_* widths from cv32e40p_apu_core_pkg; the FSM state enum and DEPTH default belong in that package.
REQ-020 SHALL place the tag FIFO, including the bypass and the hazard compare vector, in sub-module cv32e40p_apu_tag_fifo.

Verification
REQ-021 Single op with waddr=5, gnt 2 cycles after apu_req_o, rvalid 3 cycles later with rdata=0x3F800000 -> one wb_valid_o with waddr=5, data=0x3F800000.
REQ-022 Zero-latency FPU: gnt and rvalid in the same cycle, count 0 -> wb_valid_o next cycle with the correct waddr, count stays 0, err_o=0.
REQ-023 Issue 4 ops (waddr 1,2,3,4) with no responses -> req_ready_o=0 at count 4, hazard_o=1 for chk_addr_i=3 and 0 for 7; then 4 responses -> wb waddrs 1,2,3,4 in order.
REQ-024 Hold apu_gnt_i low 10 cycles -> apu_req_o and payload unchanged throughout, req_ready_o=0.
REQ-025 rst_i asserted with 2 ops in flight, then one rvalid -> all outputs 0 after reset, err_o=1, no wb_valid_o.
REQ-026 Spurious rvalid after reset with idle block -> err_o=1 and stays 1 until the next rst_i.
